// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and default frame timing, used by uart_tx and uart_rx.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned SAMPLE_RATE_DEF       = 16;
    localparam int unsigned DATA_BIT_NUM_DEF      = 8;
    localparam int unsigned STOP_BIT_DURATION_DEF = 16;

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-in / serial-out handshake between a producer (master) and the UART transmitter (slave).
interface uart_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    modport master (output tx_start, tx_data, input tx, tx_busy, tx_done);
    modport slave  (input tx_start, tx_data, output tx, tx_busy, tx_done);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter on the 16x sample clock: start bit, LSB-first data, stop bit, no parity.
//   state | meaning
//   IDLE  | line high, waiting for tx_start
//   START | start bit (low) for SAMPLE_RATE cycles
//   DATA  | data bits, LSB first, SAMPLE_RATE cycles each
//   STOP  | stop bit (high) for STOP_BIT_DURATION cycles, then tx_done
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned SAMPLE_RATE       = SAMPLE_RATE_DEF,
    parameter int unsigned DATA_BIT_NUM      = DATA_BIT_NUM_DEF,
    parameter int unsigned STOP_BIT_DURATION = STOP_BIT_DURATION_DEF
) (
    input  logic     baud_rate_sample_clk,
    input  logic     reset,
    uart_tx_if.slave bus
);

    localparam int unsigned TICK_SPAN = umax(SAMPLE_RATE, STOP_BIT_DURATION);
    localparam int unsigned TW        = (TICK_SPAN > 1) ? $clog2(TICK_SPAN) : 1;
    localparam int unsigned BW        = (DATA_BIT_NUM > 1) ? $clog2(DATA_BIT_NUM) : 1;

    localparam logic [TW-1:0] SAMPLE_LAST = TW'(SAMPLE_RATE - 1);
    localparam logic [TW-1:0] STOP_LAST   = TW'(STOP_BIT_DURATION - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_BIT_NUM - 1);

    uart_state_e   state;
    uart_state_e   state_nxt;
    logic [TW-1:0] tick;
    logic [BW-1:0] bit_idx;
    logic [7:0]    shift_reg;
    logic          tx_q;
    logic          busy_q;
    logic          done_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.tx_start) state_nxt = START;
            START:   if (tick == SAMPLE_LAST) state_nxt = DATA;
            DATA:    if (tick == SAMPLE_LAST && bit_idx == BIT_LAST) state_nxt = STOP;
            STOP:    if (tick == STOP_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // shift_reg[0] always holds the bit currently on the line during DATA
    always_ff @(posedge baud_rate_sample_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tick      <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (bus.tx_start) begin
                        shift_reg <= bus.tx_data;
                        tick      <= '0;
                        bit_idx   <= '0;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                START: begin
                    if (tick == SAMPLE_LAST) begin
                        tick <= '0;
                        tx_q <= shift_reg[0];
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                DATA: begin
                    if (tick == SAMPLE_LAST) begin
                        tick <= '0;
                        if (bit_idx == BIT_LAST) begin
                            bit_idx <= '0;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            tx_q      <= shift_reg[1];
                            shift_reg <= shift_reg >> 1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (tick == STOP_LAST) begin
                        tick   <= '0;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                default: begin
                    tick <= '0;
                    tx_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: default and a small (SR=4, 7 data bits, stop 8) instance.
module tb_uart_tx;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    uart_tx_if bd ();
    uart_tx_if bs ();

    uart_tx #(.SAMPLE_RATE(16), .DATA_BIT_NUM(8), .STOP_BIT_DURATION(16)) dut (
        .baud_rate_sample_clk(clk),
        .reset(reset),
        .bus(bd.slave)
    );

    uart_tx #(.SAMPLE_RATE(4), .DATA_BIT_NUM(7), .STOP_BIT_DURATION(8)) dut_s (
        .baud_rate_sample_clk(clk),
        .reset(reset),
        .bus(bs.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic s, input logic [7:0] d);
        if (sel) begin
            bs.tx_start = s;
            bs.tx_data  = d;
        end else begin
            bd.tx_start = s;
            bd.tx_data  = d;
        end
    endtask

    function automatic logic obs_tx(input bit sel);
        return sel ? bs.tx : bd.tx;
    endfunction

    function automatic logic obs_busy(input bit sel);
        return sel ? bs.tx_busy : bd.tx_busy;
    endfunction

    function automatic logic obs_done(input bit sel);
        return sel ? bs.tx_done : bd.tx_done;
    endfunction

    // Line level after edge k of a frame (edge 0 = accepting edge)
    function automatic logic exp_tx(input logic [7:0] d, input int k, input int sr, input int dbn);
        if (k < sr) return 1'b0;
        if (k < sr * (dbn + 1)) return d[k / sr - 1];
        return 1'b1;
    endfunction

    // Precondition: tx_start=1 and tx_data=d already driven, DUT idle.
    task automatic frame(input bit sel, input logic [7:0] d, input bit keep,
                         input logic [7:0] nd, input int pulse_at, input int abort_at);
        int sr, dbn, stp, f;
        logic [7:0] rx, mask;
        sr   = sel ? 4 : 16;
        dbn  = sel ? 7 : 8;
        stp  = sel ? 8 : 16;
        f    = sr * (dbn + 1) + stp;
        mask = 8'((1 << dbn) - 1);
        rx   = 8'h00;
        step();
        drive(sel, keep, 8'($urandom));
        for (int k = 0; k <= f; k++) begin
            if (k == abort_at) begin
                reset = 1'b1;
                #1;
                chk("abort_tx", 32'(obs_tx(sel)), 32'd1);
                chk("abort_busy", 32'(obs_busy(sel)), 32'd0);
                chk("abort_done", 32'(obs_done(sel)), 32'd0);
                return;
            end
            chk("tx", 32'(obs_tx(sel)), 32'(exp_tx(d, k, sr, dbn)));
            chk("busy", 32'(obs_busy(sel)), 32'(k < f));
            chk("done", 32'(obs_done(sel)), 32'(k == f));
            if (k >= sr && k < sr * (dbn + 1) && (k % sr) == sr / 2)
                rx[k / sr - 1] = obs_tx(sel);
            if (k == pulse_at - 1) drive(sel, 1'b1, 8'hFF);
            if (k == pulse_at) drive(sel, keep, 8'($urandom));
            if (k < f) step();
        end
        chk("rx_byte", 32'(rx), 32'(d & mask));
        if (keep) drive(sel, 1'b1, nd);
    endtask

    task automatic idle_check(input bit sel, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk("idle_tx", 32'(obs_tx(sel)), 32'd1);
            chk("idle_busy", 32'(obs_busy(sel)), 32'd0);
            chk("idle_done", 32'(obs_done(sel)), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] cur, nxt;
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        reset = 1'b1;
        repeat (3) step();
        chk("rst_tx", 32'(bd.tx), 32'd1);
        chk("rst_busy", 32'(bd.tx_busy), 32'd0);
        chk("rst_done", 32'(bd.tx_done), 32'd0);
        chk("rst_tx_s", 32'(bs.tx), 32'd1);
        reset = 1'b0;
        idle_check(1'b0, 2);

        drive(1'b0, 1'b1, 8'hA5);
        frame(1'b0, 8'hA5, 1'b0, 8'h00, -1, -1);
        idle_check(1'b0, 4);

        drive(1'b0, 1'b1, 8'h00);
        frame(1'b0, 8'h00, 1'b1, 8'hFF, -1, -1);
        frame(1'b0, 8'hFF, 1'b0, 8'h00, -1, -1);
        idle_check(1'b0, 4);

        drive(1'b0, 1'b1, 8'h3C);
        frame(1'b0, 8'h3C, 1'b0, 8'h00, 50, -1);
        idle_check(1'b0, 20);

        drive(1'b0, 1'b1, 8'h00);
        frame(1'b0, 8'h00, 1'b0, 8'h00, -1, 70);
        repeat (3) begin
            step();
            chk("rst_hold_tx", 32'(bd.tx), 32'd1);
            chk("rst_hold_done", 32'(bd.tx_done), 32'd0);
        end
        reset = 1'b0;
        idle_check(1'b0, 5);
        drive(1'b0, 1'b1, 8'h81);
        frame(1'b0, 8'h81, 1'b0, 8'h00, -1, -1);
        idle_check(1'b0, 3);

        drive(1'b1, 1'b1, 8'h80);
        frame(1'b1, 8'h80, 1'b0, 8'h00, -1, -1);
        idle_check(1'b1, 2);
        drive(1'b1, 1'b1, 8'hAA);
        frame(1'b1, 8'hAA, 1'b0, 8'h00, -1, -1);
        idle_check(1'b1, 2);
        for (int i = 0; i < 4; i++) begin
            cur = 8'($urandom);
            drive(1'b1, 1'b1, cur);
            frame(1'b1, cur, 1'b0, 8'h00, -1, -1);
            idle_check(1'b1, 1);
        end

        cur = 8'($urandom);
        drive(1'b0, 1'b1, cur);
        for (int i = 0; i < 256; i++) begin
            nxt = 8'($urandom);
            frame(1'b0, cur, (i < 255), nxt, -1, -1);
            cur = nxt;
        end
        idle_check(1'b0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
